// File: rtl/seq_addsub_pkg.sv
// Shared ALU definitions: op encodings and the
// sequencer state type for the multi-cycle adder.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/seq_addsub_if.sv
// Request/result bundle for seq_addsub.
// The requester drives start/op/operands.
interface seq_addsub_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/seq_addsub_chunk_rca.sv
// CHUNK-bit ripple-carry slice; also exposes the
// carry into its top bit for overflow detection.
module chunk_rca #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] z,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign z[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) |
                    (c[i] & (x[i] ^ y[i]));
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle add/sub: one CHUNK-bit slice per
// clock through a single shared ripple slice.
module seq_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic         clk,
  input logic         rst_n,
  seq_addsub_if.slave bus
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ?
                       $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);
  localparam logic [WIDTH-1:0] SMASK =
    WIDTH'({CHUNK{1'b1}});

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q;
  logic             ovf_q, done_q;

  logic             accept, last;
  logic [31:0]      sh;
  logic [WIDTH-1:0] mask, sum_d;
  logic [CHUNK-1:0] x, y, z;
  logic             co, cmsb;

  assign accept = (state_q == IDLE) & bus.start;
  assign last   = (idx_q == LAST);
  assign sh     = 32'(idx_q) * CHUNK;
  assign x      = CHUNK'(a_q >> sh);
  assign y      = CHUNK'(b_q >> sh);
  assign mask   = SMASK << sh;
  assign sum_d  = (sum_q & ~mask) |
                  ((WIDTH'(z) << sh) & mask);

  chunk_rca #(
    .CHUNK(CHUNK)
  ) u_rca (
    .x     (x),
    .y     (y),
    .cin   (carry_q),
    .z     (z),
    .cout  (co),
    .c_msb (cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
  end

  // Subtract is folded in at capture: a + ~b + ~cin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.b ^
                   {WIDTH{bus.op == OP_SUB}};
        carry_q <= bus.cin ^ bus.op;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        sum_q   <= sum_d;
        carry_q <= co;
        if (last) begin
          cout_q <= co;
          ovf_q  <= cmsb ^ co;
        end else begin
          idx_q  <= idx_q + 1'b1;
        end
      end
    end
  end

  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed + randomized bench for seq_addsub,
// with a parallel sweep over WIDTH/CHUNK.
module tb_seq_addsub;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_sw;
  int   n_vec   = 0;
  int   n_bad   = 0;
  int   sw_done = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // Plain-integer reference: a+b+cin or a-b-cin.
  function automatic void ref_op(
    input  int          w,
    input  bit          op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  bit          ci,
    output logic [31:0] s,
    output bit          co,
    output bit          ov
  );
    longint m, ua, ub, sa, sb, c, ur, sr;
    m  = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    c  = ci ? 1 : 0;
    sa = a[w-1] ? ua - m : ua;
    sb = b[w-1] ? ub - m : ub;
    if (op) begin
      ur = ua - ub - c;
      sr = sa - sb - c;
      co = (ur >= 0);
    end else begin
      ur = ua + ub + c;
      sr = sa + sb + c;
      co = (ur >= m);
    end
    s  = 32'(ur & (m - 1));
    ov = (sr >= m / 2) || (sr < -(m / 2));
  endfunction

  // ---------------- directed instance ----------
  seq_addsub_if #(.WIDTH(16)) m ();

  seq_addsub #(
    .WIDTH(16),
    .CHUNK(4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  task automatic run_op(input  bit          op,
                        input  logic [15:0] a,
                        input  logic [15:0] b,
                        input  bit          ci,
                        output int          lat,
                        output int          bcnt);
    m.op    = op;
    m.a     = a;
    m.b     = b;
    m.cin   = ci;
    m.start = 1'b1;
    @(posedge clk);
    #1;
    m.start = 1'b0;
    m.a     = 16'($urandom);
    m.b     = 16'($urandom);
    m.op    = 1'($urandom);
    m.cin   = 1'($urandom);
    lat     = 0;
    bcnt    = m.busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (m.done) begin
        lat = k;
        break;
      end
      if (m.busy) bcnt++;
    end
  endtask

  task automatic run_chk(input string       tag,
                         input bit          op,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         input bit          ci,
                         input logic [15:0] es,
                         input bit          eco,
                         input bit          eov);
    int lat, bcnt;
    run_op(op, a, b, ci, lat, bcnt);
    check({tag, "_lat"},  lat,    5);
    check({tag, "_busy"}, bcnt,   5);
    check({tag, "_sum"},  m.sum,  es);
    check({tag, "_cout"}, m.cout, eco);
    check({tag, "_ovf"},  m.ovf,  eov);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, m.done, 1'b0);
  endtask

  initial begin
    int          dn, dk, prev, cnt;
    logic [15:0] gs;

    rst_n   = 1'b0;
    m.start = 1'b0;
    m.op    = OP_ADD;
    m.a     = '0;
    m.b     = '0;
    m.cin   = 1'b0;
    #12;
    check("rst_busy", m.busy, 1'b0);
    check("rst_done", m.done, 1'b0);
    check("rst_sum",  m.sum,  16'h0);
    check("rst_cout", m.cout, 1'b0);
    check("rst_ovf",  m.ovf,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_chk("add1", OP_ADD, 16'h1234, 16'h4321,
            1'b0, 16'h5555, 1'b0, 1'b0);
    run_chk("addc", OP_ADD, 16'hFFFF, 16'h0001,
            1'b0, 16'h0000, 1'b1, 1'b0);
    run_chk("addv", OP_ADD, 16'h7FFF, 16'h0001,
            1'b0, 16'h8000, 1'b0, 1'b1);
    run_chk("sub1", OP_SUB, 16'h0005, 16'h0007,
            1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_chk("subv", OP_SUB, 16'h8000, 16'h0001,
            1'b0, 16'h7FFF, 1'b1, 1'b1);
    run_chk("subb", OP_SUB, 16'h0010, 16'h0003,
            1'b1, 16'h000C, 1'b1, 1'b0);

    // start pulses in RUN and in DONE are dropped
    m.op    = OP_ADD;
    m.a     = 16'h1111;
    m.b     = 16'h2222;
    m.cin   = 1'b0;
    m.start = 1'b1;
    @(posedge clk);
    #1;
    m.start = 1'b0;
    dn = 0;
    dk = 0;
    gs = '0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2 || k == 5) begin
        m.start = 1'b1;
        m.op    = OP_SUB;
        m.a     = 16'hAAAA;
        m.b     = 16'h5555;
      end
      @(posedge clk);
      #1;
      m.start = 1'b0;
      if (m.done) begin
        dn++;
        dk = k;
        gs = m.sum;
      end
    end
    check("ign_pulses", dn, 1);
    check("ign_lat",    dk, 5);
    check("ign_sum",    gs, 16'h3333);

    // start held high: one op every NCH+2 cycles
    m.op    = OP_ADD;
    m.a     = 16'h0100;
    m.b     = 16'h0023;
    m.cin   = 1'b0;
    m.start = 1'b1;
    prev = -1;
    cnt  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (m.done) begin
        cnt++;
        if (prev >= 0) check("hold_gap", k - prev, 6);
        check("hold_sum", m.sum, 16'h0123);
        prev = k;
      end
    end
    check("hold_cnt", cnt, 3);
    m.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // asynchronous reset in the middle of RUN
    m.op    = OP_ADD;
    m.a     = 16'h1234;
    m.b     = 16'h1111;
    m.start = 1'b1;
    @(posedge clk);
    #1;
    m.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sum",  m.sum,  16'h0);
    check("arst_cout", m.cout, 1'b0);
    check("arst_ovf",  m.ovf,  1'b0);
    check("arst_busy", m.busy, 1'b0);
    check("arst_done", m.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (m.done) cnt++;
    end
    check("arst_nodone", cnt, 0);
    run_chk("post", OP_ADD, 16'h0001, 16'h0001,
            1'b0, 16'h0002, 1'b0, 1'b0);

    for (int k = 0; k < 80000 && sw_done < 8; k++)
      @(posedge clk);
    check("sweep_complete", sw_done, 8);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  // ---------------- parameter sweep ------------
  function automatic int sw_w(input int g);
    case (g)
      0, 1:       return 8;
      2, 3, 4:    return 16;
      default:    return 32;
    endcase
  endfunction

  function automatic int sw_c(input int g);
    case (g)
      0, 2, 5:    return 1;
      1, 3, 6:    return 4;
      default:    return 16;
    endcase
  endfunction

  initial begin
    rst_sw = 1'b0;
    #17;
    rst_sw = 1'b1;
  end

  for (genvar g = 0; g < 8; g++) begin : g_sw
    localparam int W = sw_w(g);
    localparam int C = sw_c(g);
    localparam int N = W / C;
    localparam logic [W-1:0] MSB = W'(1) << (W - 1);

    seq_addsub_if #(.WIDTH(W)) sif ();

    seq_addsub #(
      .WIDTH(W),
      .CHUNK(C)
    ) u_sw (
      .clk   (clk),
      .rst_n (rst_sw),
      .bus   (sif)
    );

    function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      v = W'($urandom);
      case ($urandom_range(0, 7))
        0:       v = '0;
        1:       v = '1;
        2:       v = MSB;
        3:       v = ~MSB;
        default: ;
      endcase
      return v;
    endfunction

    initial begin
      logic [W-1:0] va, vb;
      logic [31:0]  es;
      bit           vop, vci, eco, eov;
      int           lat;
      string        pfx;

      pfx       = $sformatf("w%0dc%0d", W, C);
      sif.start = 1'b0;
      sif.op    = OP_ADD;
      sif.a     = '0;
      sif.b     = '0;
      sif.cin   = 1'b0;
      wait (rst_sw === 1'b1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 1000; i++) begin
        vop = 1'($urandom);
        vci = 1'($urandom);
        va  = pick();
        vb  = pick();
        ref_op(W, vop, 32'(va), 32'(vb), vci,
               es, eco, eov);
        sif.op    = vop;
        sif.a     = va;
        sif.b     = vb;
        sif.cin   = vci;
        sif.start = 1'b1;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        sif.a     = W'($urandom);
        sif.b     = W'($urandom);
        lat = 0;
        for (int k = 1; k <= N + 5; k++) begin
          @(posedge clk);
          #1;
          if (sif.done) begin
            lat = k;
            break;
          end
        end
        check({pfx, "_lat"},  lat,      N + 1);
        check({pfx, "_sum"},  sif.sum,  es[W-1:0]);
        check({pfx, "_cout"}, sif.cout, eco);
        check({pfx, "_ovf"},  sif.ovf,  eov);
      end
      sw_done++;
    end
  end

endmodule

// File: doc/seq_addsub.md
# seq_addsub

Parametrised multi-cycle adder/subtractor for the ALU datapath. It processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock, through a single shared ripple-carry slice. Compared with the fixed 16-bit combinational adder, it adds a start/done handshake, a subtract mode, borrow-in, signed-overflow detection and a selectable area/latency trade-off.

## Interface
- WIDTH, 16: operand and result width; WIDTH % CHUNK == 0 is required.
- CHUNK, 4: bits processed per cycle; 1 <= CHUNK <= WIDTH.
- clk  in  1  rising-edge clock (single clock domain).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = add, 1 = subtract (a − b).
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- cin  in  1  carry-in for add, borrow-in for subtract; captured on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of the MSB; for subtract, 1 = no borrow.
- ovf  out  1  two's-complement overflow.

## Operation
- NCH = WIDTH/CHUNK. States: IDLE, RUN, DONE.
- **IDLE, start=1:**
  - Capture a, b ^ {WIDTH{op}}, and carry = cin ^ op.
  - Clear slice index idx to 0; go to RUN.
  - sum/cout/ovf keep their previous values until the first RUN write.
- **RUN, each cycle:**
  - Slice idx, bits [idx*CHUNK +: CHUNK], goes through the chunk adder with the registered carry.
  - The result slice is written into sum and the slice carry-out is registered.
  - idx == NCH−1: register cout, set ovf = carry-into-MSB ^ carry-out-of-MSB, go to DONE. Otherwise idx++.
- **DONE:** done=1 for exactly one cycle, then go to IDLE.
- **Output hold:** sum, cout and ovf hold until the next accepted start.
- **start while busy** (RUN or DONE) is ignored, not queued. Operand inputs are don't-care after capture.
- **Subtract semantics:** a + ~b + (1 ^ cin). cin=1 in subtract mode means borrow-in, giving a − b − 1.
- **Width rules:**
  - All arithmetic is modulo 2^WIDTH.
  - idx width is clog2(NCH), minimum 1.
  - NCH=1 is legal and gives one RUN cycle.
- **Reset** (asynchronous, any state): state=IDLE, idx=0, busy=0, done=0, sum=0, cout=0, ovf=0, internal carry=0. An operation in flight is aborted and produces no done pulse.

## Timing
- Start accepted at edge T.
  - RUN occupies edges T+1 … T+NCH.
  - done=1 and results valid in the cycle after edge T+NCH+1.
  - Latency NCH+1 cycles from acceptance to done.
- busy rises the cycle after acceptance and falls together with done.
- Next start is accepted at the first edge where state is IDLE, so back-to-back throughput is one operation per NCH+2 cycles.
- The combinational path is one CHUNK-bit ripple only. Outputs are all registered; no input-to-output combinational paths.

## Structure
- **Shared package alu_pkg:**
  - op encodings OP_ADD=1'b0, OP_SUB=1'b1.
  - state enum {IDLE, RUN, DONE}.
- **Sub-module chunk_rca:**
  - Parametrised CHUNK-bit combinational ripple-carry slice.
  - Inputs: x, y, cin. Outputs: z, cout, and c_msb (the carry into its top bit, used for ovf).
  - One instance, reused every cycle.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless noted.
1. add 0x1234 + 0x4321, cin=0 -> sum 0x5555, cout 0, ovf 0; done exactly 5 cycles after the accepting edge; busy high for 5 cycles.
2. add 0xFFFF + 0x0001 (carry ripples through all 4 slices) -> 0x0000, cout 1, ovf 0. Then add 0x7FFF + 0x0001 -> 0x8000, cout 0, ovf 1.
3. sub 0x0005 − 0x0007 -> 0xFFFE, cout 0, ovf 0. Sub 0x8000 − 0x0001 -> 0x7FFF, cout 1, ovf 1. Sub 0x0010 − 0x0003 with cin=1 -> 0x000C.
4. start pulsed during RUN and during DONE with different operands -> ignored; the first result is unchanged and a single done pulse is seen. start held high continuously -> operations at a spacing of 6 cycles.
5. rst_n asserted asynchronously mid-RUN (idx=2) -> outputs immediately 0, busy 0, no done. A following add 0x0001 + 0x0001 -> 0x0002.
6. Parameter sweep CHUNK ∈ {1, 4, 16}, WIDTH ∈ {8, 16, 32}: 1000 random op/a/b/cin each, compared against a reference model for sum/cout/ovf and latency NCH+1.
